// File: rtl/tt_scan_driver_if.sv
// Host-side handshake for tt_scan_driver: transaction request, byte to load, status and returned byte.
interface tt_scan_driver_if;
   logic       start;
   logic [7:0] data_in;
   logic       busy;
   logic       done;
   logic [7:0] data_out;

   modport master (output start, output data_in, input busy, input done, input data_out);
   modport slave  (input start, input data_in, output busy, output done, output data_out);
endinterface

// File: rtl/tt_scan_driver.sv
// Controller end of an 8-bit Tiny Tapeout scan-chain slot: capture, shift 8 bits, latch.
// Optional SCAN_DRIVER_AUTO_EN runs transactions back-to-back without a start request.
module tt_scan_driver #(
   parameter int CLK_DIV = 2
) (
   input  logic            clk12MHz,
   input  logic            reset,
   tt_scan_driver_if.slave host,
   input  logic            scan_data_in,
   output logic            scan_clk_out,
   output logic            scan_data_out,
   output logic            scan_select,
   output logic            scan_latch_en
);
   localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CAP_LO = 3'd1,
      CAP_HI = 3'd2,
      SH_LO  = 3'd3,
      SH_HI  = 3'd4,
      LATCH  = 3'd5,
      DONE   = 3'd6
   } state_t;

   state_t        state_r;
   logic [CW-1:0] phase_cnt_r;
   logic [3:0]    bit_cnt_r;
   logic [7:0]    tx_r;
   logic [7:0]    rx_r;
   logic [7:0]    data_out_r;
   logic          sclk_r;
   logic          sdo_r;
   logic          sel_r;
   logic          le_r;
   logic          busy_r;
   logic          done_r;
   logic          phase_end_s;
   logic          phase_first_s;
   logic          go_s;

   assign phase_end_s   = (phase_cnt_r == {CW{1'b0}});
   assign phase_first_s = (phase_cnt_r == RELOAD);

`ifdef SCAN_DRIVER_AUTO_EN
   assign go_s = 1'b1;
`else
   assign go_s = host.start;
`endif

   // Scan sequencer; outputs are decoded from the registered state, so they trail it by one cycle.
   always_ff @(posedge clk12MHz) begin
      if (reset) begin
         state_r     <= IDLE;
         phase_cnt_r <= RELOAD;
         bit_cnt_r   <= 4'd0;
         tx_r        <= 8'h00;
         rx_r        <= 8'h00;
         data_out_r  <= 8'h00;
         sclk_r      <= 1'b0;
         sdo_r       <= 1'b0;
         sel_r       <= 1'b0;
         le_r        <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         sclk_r <= 1'b0;
         sdo_r  <= 1'b0;
         sel_r  <= 1'b0;
         le_r   <= 1'b0;
         done_r <= 1'b0;
`ifdef SCAN_DRIVER_AUTO_EN
         busy_r <= 1'b1;
`else
         busy_r <= (state_r != IDLE);
`endif
         case (state_r)
            CAP_LO: sel_r <= 1'b1;
            CAP_HI: begin
               sel_r  <= 1'b1;
               sclk_r <= 1'b1;
            end
            SH_LO: sdo_r <= tx_r[7];
            SH_HI: begin
               sclk_r <= 1'b1;
               sdo_r  <= sdo_r;
            end
            LATCH: le_r <= 1'b1;
            DONE: begin
               if (phase_first_s || (CLK_DIV == 1)) begin
                  done_r     <= 1'b1;
                  data_out_r <= rx_r;
               end else begin
`ifndef SCAN_DRIVER_AUTO_EN
                  done_r     <= 1'b1;
                  data_out_r <= rx_r;
`endif
               end
            end
            default: begin
            end
         endcase

         // Every timed phase starts from a fresh reload; IDLE keeps the counter primed.
         if ((state_r != IDLE) && !phase_end_s) begin
            phase_cnt_r <= phase_cnt_r - CW'(1);
         end else begin
            phase_cnt_r <= RELOAD;
         end

         case (state_r)
            IDLE: begin
               if (go_s) begin
                  tx_r      <= host.data_in;
                  bit_cnt_r <= 4'd0;
                  state_r   <= CAP_LO;
               end else begin
                  state_r   <= IDLE;
               end
            end
            CAP_LO: if (phase_end_s) state_r <= CAP_HI; else state_r <= CAP_LO;
            CAP_HI: if (phase_end_s) state_r <= SH_LO;  else state_r <= CAP_HI;
            SH_LO: begin
               if (phase_end_s) begin
                  bit_cnt_r <= bit_cnt_r + 4'd1;
                  state_r   <= SH_HI;
               end else begin
                  state_r   <= SH_LO;
               end
            end
            SH_HI: begin
               // Sample on the edge where the scan clock rises: this is the chain's pre-edge tail bit.
               if (phase_first_s) begin
                  rx_r <= {rx_r[6:0], scan_data_in};
                  tx_r <= {tx_r[6:0], 1'b0};
               end else begin
                  rx_r <= rx_r;
               end
               if (phase_end_s) begin
                  state_r <= (bit_cnt_r == 4'd8) ? LATCH : SH_LO;
               end else begin
                  state_r <= SH_HI;
               end
            end
            LATCH: if (phase_end_s) state_r <= DONE; else state_r <= LATCH;
            DONE: begin
`ifdef SCAN_DRIVER_AUTO_EN
               if (phase_end_s) begin
                  tx_r      <= host.data_in;
                  bit_cnt_r <= 4'd0;
                  state_r   <= CAP_LO;
               end else begin
                  state_r   <= DONE;
               end
`else
               state_r <= IDLE;
`endif
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign scan_clk_out  = sclk_r;
   assign scan_data_out = sdo_r;
   assign scan_select   = sel_r;
   assign scan_latch_en = le_r;
   assign host.busy     = busy_r;
   assign host.done     = done_r;
   assign host.data_out = data_out_r;
endmodule

// File: tb/tb_tt_scan_driver.sv
// Directed scoreboard bench for tt_scan_driver: two instances (CLK_DIV=2 and 1), each with a loopback chain model.
module tb_tt_scan_driver;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tt_scan_driver_if h0 ();
   tt_scan_driver_if h1 ();

   logic sclk0, sdo0, sel0, le0, sdi0;
   logic sclk1, sdo1, sel1, le1, sdi1;

   tt_scan_driver #(.CLK_DIV(2)) dut0 (
      .clk12MHz(clk), .reset(reset), .host(h0), .scan_data_in(sdi0),
      .scan_clk_out(sclk0), .scan_data_out(sdo0), .scan_select(sel0), .scan_latch_en(le0));
   tt_scan_driver #(.CLK_DIV(1)) dut1 (
      .clk12MHz(clk), .reset(reset), .host(h1), .scan_data_in(sdi1),
      .scan_clk_out(sclk1), .scan_data_out(sdo1), .scan_select(sel1), .scan_latch_en(le1));

   // Loopback chain models: capture module outputs, shift toward the tail, latch into module inputs.
   logic [7:0] chain0 = 8'h00, min0 = 8'h00, bits0 = 8'h00, mout0;
   logic [7:0] chain1 = 8'h00, min1 = 8'h00, bits1 = 8'h00, mout1;
   int cap0 = 0, sh0 = 0, lat0 = 0, sh1 = 0, lat1 = 0;
   longint tlast1 = 0, per1 = 0;

   always @(posedge sclk0) begin
      if (sel0) begin
         chain0 <= mout0;
         cap0   <= cap0 + 1;
      end else begin
         chain0 <= {chain0[6:0], sdo0};
         bits0  <= {bits0[6:0], sdo0};
         sh0    <= sh0 + 1;
      end
   end
   always @(posedge le0) begin
      min0 <= chain0;
      lat0 <= lat0 + 1;
   end
   assign sdi0 = chain0[7];

   always @(posedge sclk1) begin
      if (sel1) begin
         chain1 <= mout1;
      end else begin
         chain1 <= {chain1[6:0], sdo1};
         bits1  <= {bits1[6:0], sdo1};
         sh1    <= sh1 + 1;
         per1   <= longint'($time) - tlast1;
         tlast1 <= longint'($time);
      end
   end
   always @(posedge le1) begin
      min1 <= chain1;
      lat1 <= lat1 + 1;
   end
   assign sdi1 = chain1[7];

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic kick(input int d, input logic [7:0] din, input bit hold);
      @(negedge clk);
      if (d == 0) begin h0.data_in = din; h0.start = 1'b1; end
      else        begin h1.data_in = din; h1.start = 1'b1; end
      @(posedge clk); #1;
      if (!hold) begin h0.start = 1'b0; h1.start = 1'b0; end
   endtask

   // Counts edges until done is seen, then pops the scoreboard and compares data_out.
   task automatic wait_done(input int d, input string tag, output int n);
      logic       seen;
      logic [7:0] exp;
      logic [7:0] obs;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(posedge clk); #1;
         n++;
         seen = (d == 0) ? h0.done : h1.done;
      end
      check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
      if (d == 0) begin exp = q0.pop_front(); obs = h0.data_out; end
      else        begin exp = q1.pop_front(); obs = h1.data_out; end
      check({tag, "_data_out"}, {24'd0, obs}, {24'd0, exp});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, c_base, s_base, l_base;
      reset = 1'b1;
      h0.start = 1'b0; h0.data_in = 8'h00;
      h1.start = 1'b0; h1.data_in = 8'h00;
      mout0 = 8'h3C;
      mout1 = 8'h81;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out0", {26'd0, sclk0, sdo0, sel0, le0, h0.busy, h0.done}, 32'd0);
      check("rst_out1", {18'd0, sclk1, sdo1, sel1, le1, h1.busy, h1.done, h1.data_out}, 32'd0);
      check("rst_dout0", {24'd0, h0.data_out}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
`ifdef SCAN_DRIVER_AUTO_EN
      mout0 = 8'h11;
      q0.push_back(8'h11);
      wait_done(0, "auto1", n);
      mout0 = 8'h22;
      q0.push_back(8'h22);
      wait_done(0, "auto2", n);
      check("auto2_period", n, 32'd40);
      mout0 = 8'h33;
      q0.push_back(8'h33);
      wait_done(0, "auto3", n);
      check("auto3_period", n, 32'd40);
      check("auto_busy", {31'd0, h0.busy}, 32'd1);
`else
      // Basic transaction, CLK_DIV=2
      c_base = cap0; s_base = sh0; l_base = lat0;
      q0.push_back(8'h3C);
      kick(0, 8'hA5, 1'b0);
      wait_done(0, "a5", n);
      check("a5_latency", n, 32'd39);
      check("a5_busy_at_done", {31'd0, h0.busy}, 32'd1);
      check("a5_captures", cap0 - c_base, 32'd1);
      check("a5_shifts", sh0 - s_base, 32'd8);
      check("a5_bits", {24'd0, bits0}, 32'h0000_00A5);
      check("a5_latches", lat0 - l_base, 32'd1);
      check("a5_mod_in", {24'd0, min0}, 32'h0000_00A5);
      @(posedge clk); #1;
      check("a5_done_after", {31'd0, h0.done}, 32'd0);
      check("a5_busy_after", {31'd0, h0.busy}, 32'd0);

      // start held high: one transaction, re-accepted only in the first IDLE cycle
      mout0 = 8'h77;
      q0.push_back(8'h77);
      q0.push_back(8'h77);
      kick(0, 8'h5A, 1'b1);
      wait_done(0, "hold1", n);
      check("hold1_latency", n, 32'd39);
      wait_done(0, "hold2", n);
      h0.start = 1'b0;
      check("hold2_latency", n, 32'd40);
      check("hold_mod_in", {24'd0, min0}, 32'h0000_005A);

      // Reset during the 4th shift-clock high phase
      mout0 = 8'hC3;
      s_base = sh0; l_base = lat0;
      kick(0, 8'h12, 1'b0);
      n = 0;
      while (!((sh0 - s_base == 4) && sclk0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("rst_mid_reach", sh0 - s_base, 32'd4);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_out", {26'd0, sclk0, sdo0, sel0, le0, h0.busy, h0.done}, 32'd0);
      check("rst_mid_dout", {24'd0, h0.data_out}, 32'd0);
      reset = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      check("rst_mid_latches", lat0 - l_base, 32'd0);
      check("rst_mid_idle", {30'd0, h0.busy, h0.done}, 32'd0);

      // CLK_DIV=1
      q1.push_back(8'h81);
      kick(1, 8'hFF, 1'b0);
      wait_done(1, "div1", n);
      check("div1_latency", n, 32'd20);
      check("div1_mod_in", {24'd0, min1}, 32'h0000_00FF);
      check("div1_sclk_period", 32'(per1), 32'd20);
      check("div1_latches", lat1, 32'd1);

      // data_in changes after acceptance have no effect
      mout0 = 8'h5E;
      q0.push_back(8'h5E);
      kick(0, 8'h0F, 1'b0);
      @(negedge clk);
      h0.data_in = 8'hF0;
      wait_done(0, "din", n);
      check("din_mod_in", {24'd0, min0}, 32'h0000_000F);
      check("din_bits", {24'd0, bits0}, 32'h0000_000F);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
